// File: rtl/gpio_out_drv_if.sv
// Command/pad bundle between the peripheral register block (master) and the
// registered GPIO output stage (slave).
interface gpio_out_drv_if #(
  parameter int unsigned NUM_PINS = 8,
  parameter int unsigned CNT_W    = 16
);
  logic                wr_en_i;
  logic [1:0]          wr_op_i;
  logic [NUM_PINS-1:0] wr_data_i;
  logic                oe_wr_i;
  logic [NUM_PINS-1:0] oe_data_i;
  logic                pulse_start_i;
  logic [NUM_PINS-1:0] pulse_mask_i;
  logic [CNT_W-1:0]    pulse_len_i;
  logic                pulse_busy_o;
  logic                pulse_done_o;
  logic [NUM_PINS-1:0] pad_o;
  logic [NUM_PINS-1:0] pad_oe_o;

  modport master (
    output wr_en_i, wr_op_i, wr_data_i, oe_wr_i, oe_data_i,
    output pulse_start_i, pulse_mask_i, pulse_len_i,
    input  pulse_busy_o, pulse_done_o, pad_o, pad_oe_o
  );

  modport slave (
    input  wr_en_i, wr_op_i, wr_data_i, oe_wr_i, oe_data_i,
    input  pulse_start_i, pulse_mask_i, pulse_len_i,
    output pulse_busy_o, pulse_done_o, pad_o, pad_oe_o
  );
endinterface

// File: rtl/gpio_out_drv.sv
// Registered GPIO output stage: per-pin data/enable registers with
// write/set/clear/toggle commands and a one-shot masked inversion pulse.
module gpio_out_drv #(
  parameter int unsigned NUM_PINS = 8,
  parameter int unsigned CNT_W    = 16
) (
  input logic             clk_i,
  input logic             rstn_i,
  gpio_out_drv_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StPulse, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e              state_q, state_d;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] oe_q, oe_d;
  logic [NUM_PINS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      out_q   <= '0;
      oe_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    out_d = out_q;
    if (bus.wr_en_i) begin
      unique case (bus.wr_op_i)
        2'b00:   out_d = bus.wr_data_i;
        2'b01:   out_d = out_q | bus.wr_data_i;
        2'b10:   out_d = out_q & ~bus.wr_data_i;
        default: out_d = out_q ^ bus.wr_data_i;
      endcase
    end
    oe_d = bus.oe_wr_i ? bus.oe_data_i : oe_q;
  end

  // Starts are only honoured in IDLE/DONE; a zero length goes straight to DONE.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.pulse_start_i) begin
          if (bus.pulse_len_i != '0) begin
            mask_d  = bus.pulse_mask_i;
            cnt_d   = bus.pulse_len_i;
            state_d = StPulse;
          end else begin
            state_d = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StPulse: begin
        if (cnt_q == CntOne) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.pad_o        = out_q ^ ((state_q == StPulse) ? mask_q : '0);
  assign bus.pad_oe_o     = oe_q;
  assign bus.pulse_busy_o = (state_q == StPulse);
  assign bus.pulse_done_o = (state_q == StDone);

endmodule
